// File: rtl/hex_keypad_encoder.sv
// hex_keypad_encoder: scans a 4x4 keypad, debounces press/release and strobes the hex code of each new key.
module hex_keypad_encoder #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic       Clk,
    input  logic       ResetN,
    input  logic [3:0] Col,
    output logic [3:0] Row,
    output logic [3:0] Code,
    output logic       Valid,
    output logic       Pressed
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    // nibble {row, col} holds the legend of that key; row 3 carries * as E and # as F
    localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;

    typedef enum logic [1:0] {S_SCAN, S_DEB, S_HELD, S_REL} state_t;

    state_t        state_q, state_d;
    logic [3:0]    col_meta_q, col_meta_d, col_s_q, col_s_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [1:0]    row_q, row_d, col_q, col_d, low_idx;
    logic [3:0]    code_q, code_d;
    logic          valid_q, valid_d, pressed_q, pressed_d;
    logic          sample, one_low, none_low;

    // decode the synchronized columns and compute the next scan/debounce state
    always_comb begin
        col_meta_d = Col;
        col_s_d    = col_meta_q;
        sample     = dwell_q == DWELL_LAST;
        dwell_d    = sample ? '0 : dwell_q + 1'b1;
        none_low   = col_s_q == 4'hF;
        low_idx    = !col_s_q[0] ? 2'd0 : !col_s_q[1] ? 2'd1 : !col_s_q[2] ? 2'd2 : 2'd3;
        one_low    = col_s_q == ~(4'b0001 << low_idx);
        cnt_inc    = cnt_q + 1'b1;
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        cnt_d      = cnt_q;
        code_d     = code_q;
        valid_d    = 1'b0;
        pressed_d  = pressed_q;
        if (sample) begin
            case (state_q)
                S_SCAN: begin
                    if (one_low) begin
                        col_d   = low_idx;
                        cnt_d   = CNT_ONE;
                        state_d = S_DEB;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
                S_DEB: begin
                    if (one_low && low_idx == col_q) begin
                        cnt_d = cnt_inc;
                    end else begin
                        state_d = S_SCAN;
                        row_d   = row_q + 1'b1;
                    end
                end
                S_HELD: begin
                    if (none_low) begin
                        cnt_d   = CNT_ONE;
                        state_d = S_REL;
                    end
                end
                S_REL: begin
                    if (none_low) cnt_d = cnt_inc;
                    else state_d = S_HELD;
                end
            endcase
            // acceptance is checked after the step so a one-sample debounce fires straight from SCAN
            if (state_d == S_DEB && cnt_d == CNT_DONE) begin
                code_d    = KEY_MAP[{row_q, col_d, 2'b00} +: 4];
                valid_d   = 1'b1;
                pressed_d = 1'b1;
                state_d   = S_HELD;
            end
            if (state_d == S_REL && cnt_d == CNT_DONE) begin
                pressed_d = 1'b0;
                state_d   = S_SCAN;
                row_d     = row_q + 1'b1;
            end
        end
    end

    // register all state; reset drops every output at once
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            col_meta_q <= 4'hF;
            col_s_q    <= 4'hF;
            dwell_q    <= '0;
            cnt_q      <= '0;
            state_q    <= S_SCAN;
            row_q      <= 2'd0;
            col_q      <= 2'd0;
            code_q     <= 4'h0;
            valid_q    <= 1'b0;
            pressed_q  <= 1'b0;
        end else begin
            col_meta_q <= col_meta_d;
            col_s_q    <= col_s_d;
            dwell_q    <= dwell_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
            pressed_q  <= pressed_d;
        end
    end

    assign Row     = ~(4'b0001 << row_q);
    assign Code    = code_q;
    assign Valid   = valid_q;
    assign Pressed = pressed_q;
endmodule

// File: tb/tb_hex_keypad_encoder.sv
// tb_hex_keypad_encoder: keypad model plus key-level reference model for hex_keypad_encoder.
module tb_hex_keypad_encoder;
    localparam int SD = 4;
    localparam int DB = 3;

    logic        Clk = 1'b0;
    logic        ResetN = 1'b1;
    logic [15:0] keys = '0;
    logic [3:0]  Col, Row, Code;
    logic        Valid, Pressed;
    int          errors = 0;
    int          checks = 0;

    hex_keypad_encoder #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
        .Clk(Clk), .ResetN(ResetN), .Col(Col), .Row(Row), .Code(Code), .Valid(Valid), .Pressed(Pressed)
    );

    always #5 Clk = ~Clk;

    // physical keypad: a closed key shorts its column to its row while that row is driven low
    always_comb begin
        Col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!Row[r] && keys[r*4+c]) Col[c] = 1'b0;
    end

    // reference model: keys seen through a two-edge delay, judged once per dwell period
    string      kmap = "123A456B789CE0FD";
    int         m_row, m_tick, m_phase, m_cnt, m_key, m_nlow, m_low;
    logic [3:0] m_s1, m_s0, m_seen, m_code;
    logic       m_valid, m_pressed;
    byte        ch;

    always @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            m_row = 0; m_tick = 0; m_phase = 0; m_cnt = 0; m_key = 0;
            m_s1 = 4'hF; m_s0 = 4'hF; m_code = 4'h0; m_valid = 1'b0; m_pressed = 1'b0;
        end else begin
            m_seen = m_s0;
            m_s0 = m_s1;
            m_s1 = ~keys[m_row*4 +: 4];
            m_valid = 1'b0;
            if (m_tick == SD - 1) begin
                m_tick = 0;
                m_nlow = 0;
                m_low = 0;
                for (int c = 0; c < 4; c++) if (!m_seen[c]) begin m_nlow++; m_low = c; end
                if (m_phase == 0) begin
                    if (m_nlow == 1) begin m_key = m_row*4 + m_low; m_cnt = 1; m_phase = 1; end
                    else m_row = (m_row + 1) % 4;
                end else if (m_phase == 1) begin
                    if (m_nlow == 1 && m_row*4 + m_low == m_key) m_cnt++;
                    else begin m_phase = 0; m_row = (m_row + 1) % 4; end
                end else if (m_phase == 2) begin
                    if (m_nlow == 0) begin m_cnt = 1; m_phase = 3; end
                end else begin
                    if (m_nlow == 0) m_cnt++;
                    else m_phase = 2;
                end
                if (m_phase == 1 && m_cnt == DB) begin
                    ch = kmap[m_key];
                    m_code = 4'((ch >= 8'h41) ? ch - 8'h37 : ch - 8'h30);
                    m_valid = 1'b1;
                    m_pressed = 1'b1;
                    m_phase = 2;
                end
                if (m_phase == 3 && m_cnt == DB) begin
                    m_pressed = 1'b0;
                    m_phase = 0;
                    m_row = (m_row + 1) % 4;
                end
            end else begin
                m_tick++;
            end
        end
    end

    logic [9:0] obs, expv;
    assign obs = {Row, Code, Valid, Pressed};
    always_comb expv = {4'hF ^ (4'h1 << m_row), m_code, m_valid, m_pressed};

    task automatic test_reset();
        logic [3:0] seq [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
        keys = '0;
        #2 ResetN = 1'b0;
        #1;
        checks++;
        if (obs !== 10'b1110_0000_0_0) begin errors++; $display("FAIL reset_outputs got=%b want=%b", obs, 10'b1110_0000_0_0); end
        repeat (2) @(negedge Clk);
        checks++;
        if (obs !== 10'b1110_0000_0_0) begin errors++; $display("FAIL reset_hold got=%b want=%b", obs, 10'b1110_0000_0_0); end
        ResetN = 1'b1;
        for (int s = 0; s < 8; s++) begin
            repeat (SD) begin
                @(negedge Clk); checks++;
                if (obs !== expv) begin errors++; $display("FAIL track_reset t=%0t got=%b want=%b", $time, obs, expv); end
            end
            checks++;
            if (Row !== seq[s%4]) begin errors++; $display("FAIL scan_step%0d got=%b want=%b", s, Row, seq[s%4]); end
        end
    endtask

    task automatic test_hold5();
        int nv = 0, lat = -1;
        logic [3:0] cv = 4'h0;
        keys = 16'h0020;
        for (int i = 1; i <= 45; i++) begin
            @(negedge Clk); checks++;
            if (obs !== expv) begin errors++; $display("FAIL track_hold5 t=%0t got=%b want=%b", $time, obs, expv); end
            if (Valid) begin nv++; cv = Code; if (lat < 0) lat = i; end
        end
        checks++;
        if (nv !== 1 || cv !== 4'h5) begin errors++; $display("FAIL hold5_valid got n=%0d code=%h want n=1 code=5", nv, cv); end
        checks++;
        if (lat < 0 || lat > 2 + (4 + DB) * SD) begin errors++; $display("FAIL hold5_latency got=%0d want<=%0d", lat, 2 + (4 + DB) * SD); end
        checks++;
        if (Row !== 4'b1101 || Pressed !== 1'b1) begin errors++; $display("FAIL hold5_frozen got row=%b pressed=%b want row=1101 pressed=1", Row, Pressed); end
        nv = 0;
        repeat (100) begin
            @(negedge Clk); checks++;
            if (obs !== expv) begin errors++; $display("FAIL track_hold5b t=%0t got=%b want=%b", $time, obs, expv); end
            if (Valid) nv++;
        end
        checks++;
        if (nv !== 0) begin errors++; $display("FAIL hold5_repeat got=%0d want=0", nv); end
        keys = '0;
        repeat (40) begin
            @(negedge Clk); checks++;
            if (obs !== expv) begin errors++; $display("FAIL track_rel5 t=%0t got=%b want=%b", $time, obs, expv); end
        end
        checks++;
        if (Pressed !== 1'b0) begin errors++; $display("FAIL rel5_pressed got=%b want=0", Pressed); end
    endtask

    task automatic test_short_press();
        int nv = 0, np = 0, w = 0;
        while (Row !== 4'b1011 && w < 40) begin
            @(negedge Clk); w++; checks++;
            if (obs !== expv) begin errors++; $display("FAIL track_wait9 t=%0t got=%b want=%b", $time, obs, expv); end
        end
        checks++;
        if (Row !== 4'b1011) begin errors++; $display("FAIL wait_row2 got=%b want=1011", Row); end
        keys = 16'h0400;
        for (int i = 0; i < 28; i++) begin
            if (i == 8) keys = '0;
            @(negedge Clk); checks++;
            if (obs !== expv) begin errors++; $display("FAIL track_short9 t=%0t got=%b want=%b", $time, obs, expv); end
            if (Valid) nv++;
            if (Pressed) np++;
        end
        checks++;
        if (nv !== 0 || np !== 0) begin errors++; $display("FAIL short9 got valid=%0d pressed=%0d want 0 0", nv, np); end
    endtask

    task automatic test_bounce();
        int nv = 0, drops = 0;
        keys = 16'h0008;
        for (int i = 0; i < 61; i++) begin
            if (i == 45) keys = '0;
            if (i == 53) keys = 16'h0008;
            @(negedge Clk); checks++;
            if (obs !== expv) begin errors++; $display("FAIL track_bounce t=%0t got=%b want=%b", $time, obs, expv); end
            if (Valid) nv++;
            if (i >= 45 && !Pressed) drops++;
        end
        checks++;
        if (drops !== 0) begin errors++; $display("FAIL bounce_pressed got drops=%0d want=0", drops); end
        keys = '0;
        repeat (8) begin
            @(negedge Clk); checks++;
            if (obs !== expv) begin errors++; $display("FAIL track_open t=%0t got=%b want=%b", $time, obs, expv); end
            if (Valid) nv++;
        end
        checks++;
        if (Pressed !== 1'b1) begin errors++; $display("FAIL open_early got=%b want=1", Pressed); end
        repeat (30) begin
            @(negedge Clk); checks++;
            if (obs !== expv) begin errors++; $display("FAIL track_open2 t=%0t got=%b want=%b", $time, obs, expv); end
            if (Valid) nv++;
        end
        checks++;
        if (Pressed !== 1'b0 || nv !== 1) begin errors++; $display("FAIL bounce_end got pressed=%b valid=%0d want 0 1", Pressed, nv); end
    endtask

    task automatic test_star_hash();
        logic [15:0] pat [3] = '{16'h1000, 16'h4000, 16'h0003};
        logic [3:0]  want [3] = '{4'hE, 4'hF, 4'h0};
        for (int k = 0; k < 3; k++) begin
            int nv = 0;
            logic [3:0] cv = 4'h0;
            keys = pat[k];
            repeat (60) begin
                @(negedge Clk); checks++;
                if (obs !== expv) begin errors++; $display("FAIL track_key%0d t=%0t got=%b want=%b", k, $time, obs, expv); end
                if (Valid) begin nv++; cv = Code; end
            end
            checks++;
            if (k < 2 && (nv !== 1 || cv !== want[k])) begin errors++; $display("FAIL key%0d got n=%0d code=%h want n=1 code=%h", k, nv, cv, want[k]); end
            if (k == 2 && (nv !== 0 || Pressed !== 1'b0)) begin errors++; $display("FAIL two_keys got n=%0d pressed=%b want 0 0", nv, Pressed); end
            keys = '0;
            repeat (40) begin
                @(negedge Clk); checks++;
                if (obs !== expv) begin errors++; $display("FAIL track_rel%0d t=%0t got=%b want=%b", k, $time, obs, expv); end
            end
        end
    endtask

    task automatic test_reset_held();
        int nv = 0;
        logic [3:0] cv = 4'h0;
        keys = 16'h8000;
        repeat (45) begin
            @(negedge Clk); checks++;
            if (obs !== expv) begin errors++; $display("FAIL track_d t=%0t got=%b want=%b", $time, obs, expv); end
        end
        checks++;
        if (Pressed !== 1'b1 || Code !== 4'hD) begin errors++; $display("FAIL d_held got pressed=%b code=%h want 1 d", Pressed, Code); end
        ResetN = 1'b0;
        #1;
        checks++;
        if (obs !== 10'b1110_0000_0_0) begin errors++; $display("FAIL reset_mid got=%b want=%b", obs, 10'b1110_0000_0_0); end
        repeat (3) @(negedge Clk);
        ResetN = 1'b1;
        repeat (60) begin
            @(negedge Clk); checks++;
            if (obs !== expv) begin errors++; $display("FAIL track_d2 t=%0t got=%b want=%b", $time, obs, expv); end
            if (Valid) begin nv++; cv = Code; end
        end
        checks++;
        if (nv !== 1 || cv !== 4'hD) begin errors++; $display("FAIL d_after_reset got n=%0d code=%h want n=1 code=d", nv, cv); end
        keys = '0;
        repeat (40) @(negedge Clk);
    endtask

    task automatic test_random();
        for (int it = 0; it < 12; it++) begin
            int hold = $urandom_range(10, 80);
            int gap = $urandom_range(5, 60);
            keys = 16'h0001 << $urandom_range(0, 15);
            if ($urandom_range(0, 3) == 0) keys = keys | (16'h0001 << $urandom_range(0, 15));
            for (int i = 0; i < hold + gap; i++) begin
                if (i == hold) keys = '0;
                @(negedge Clk); checks++;
                if (obs !== expv) begin errors++; $display("FAIL track_rand%0d t=%0t got=%b want=%b", it, $time, obs, expv); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_hold5();
        test_short_press();
        test_bounce();
        test_star_hash();
        test_reset_held();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
